// File: rtl/vcr_mux_sequencer.sv
// Scans the four LED-regulator mux channels, samples the synchronized comparator on each,
// and pulses the latch set input when any channel tripped.
module vcr_mux_sequencer #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LATCH_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       comp_in,
    output logic [1:0] sel,
    output logic       latch_s,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        LATCH,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic       comp_meta;
    logic       comp_sync;
    logic [3:0] res_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_meta <= 1'b0;
            comp_sync <= 1'b0;
        end else begin
            comp_meta <= comp_in;
            comp_sync <= comp_meta;
        end
    end

    // result as it will stand after the current SAMPLE cycle
    always_comb begin
        res_upd     = result;
        res_upd[ch] = comp_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            cnt     <= '0;
            sel     <= '0;
            latch_s <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && !ena) begin
                state   <= IDLE;
                sel     <= '0;
                latch_s <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && ena) begin
                            result <= '0;
                            ch     <= '0;
                            cnt    <= 8'(SETTLE_CYC - 1);
                            sel    <= '0;
                            busy   <= 1'b1;
                            state  <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= SAMPLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    SAMPLE: begin
                        result <= res_upd;
                        if (ch != 2'd3) begin
                            ch    <= ch + 2'd1;
                            sel   <= ch + 2'd1;
                            cnt   <= 8'(SETTLE_CYC - 1);
                            state <= SETTLE;
                        end else if (res_upd != '0) begin
                            cnt     <= 8'(LATCH_CYC - 1);
                            sel     <= 2'd3;
                            latch_s <= 1'b1;
                            state   <= LATCH;
                        end else begin
                            sel   <= 2'd3;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    LATCH: begin
                        if (cnt == '0) begin
                            latch_s <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    DONE: begin
                        sel   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        sel     <= '0;
                        latch_s <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vcr_mux_sequencer.sv
// Scoreboard bench for vcr_mux_sequencer: stimulus pushes expected scan outcomes,
// a monitor measures each scan and checks it when done pulses.
module tb_vcr_mux_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       comp_in = 1'b0;
    logic [1:0] sel;
    logic       latch_s;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int checks = 0;
    int failures = 0;
    int comp_mode = 0;  // 0: always 0, 1: high only while sel==2, 2: always 1

    typedef struct {
        logic [3:0] res;
        int         done_cyc;
        int         lat_len;
        int         lat_start;
    } exp_t;

    exp_t sb[$];

    vcr_mux_sequencer #(.SETTLE_CYC(8), .LATCH_CYC(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .comp_in (comp_in),
        .sel     (sel),
        .latch_s (latch_s),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            comp_in = (comp_mode == 2) ? 1'b1 : (comp_mode == 1) ? (sel == 2'd2) : 1'b0;
        end
    end

    // Monitor: busy-cycle counter, latch pulse measurement, sel sequence
    initial begin
        int bcnt = 0;
        int lat = 0;
        int lat_st = 0;
        int sel_bad = 0;
        logic [1:0] exp_sel;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy) begin
                bcnt = 0; lat = 0; lat_st = 0; sel_bad = 0;
            end else begin
                bcnt++;
                exp_sel = (bcnt <= 36) ? 2'((bcnt - 1) / 9) : 2'd3;
                if (sel != exp_sel) sel_bad = 1;
                if (latch_s) begin
                    lat++;
                    if (lat_st == 0) lat_st = bcnt;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", int'(result), int'(e.res));
                        chk("done_cycle", bcnt, e.done_cyc);
                        chk("latch_len", lat, e.lat_len);
                        chk("latch_start", lat_st, e.lat_start);
                        chk("sel_sequence", sel_bad, 0);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_sel2();
        int n = 0;
        while (sel != 2'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sel2_timeout", int'(sel), 2);
    endtask

    task automatic set_mode(input int m);
        comp_mode = m;
        repeat (4) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] r, input int dc, input int ll, input int ls);
        exp_t e;
        e.res = r; e.done_cyc = dc; e.lat_len = ll; e.lat_start = ls;
        sb.push_back(e);
    endtask

    initial begin
        #3;
        chk("rst_sel", int'(sel), 0);
        chk("rst_latch", int'(latch_s), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // No trip
        set_mode(0);
        push(4'b0000, 37, 0, 0);
        pulse_start();
        wait_idle();

        // Channel 2 trips only
        set_mode(1);
        push(4'b0100, 41, 4, 37);
        pulse_start();
        wait_idle();
        repeat (3) @(negedge clk);
        chk("result_hold", int'(result), 4'b0100);

        // All channels trip
        set_mode(2);
        push(4'b1111, 41, 4, 37);
        pulse_start();
        wait_idle();

        // start during busy cycle 10 is ignored
        set_mode(1);
        push(4'b0100, 41, 4, 37);
        pulse_start();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("no_retrigger", int'(busy), 0);

        // Abort via ena during channel 2 settle
        set_mode(2);
        pulse_start();
        wait_sel2();
        ena = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sel", int'(sel), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_latch", int'(latch_s), 0);
        chk("abort_result", int'(result), 4'b0011);
        @(negedge clk);
        ena = 1'b1;

        // Reset mid-scan, then full restart
        pulse_start();
        wait_sel2();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_latch", int'(latch_s), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_result", int'(result), 0);
        @(negedge clk);
        chk("midrst_idle", int'(busy), 0);
        rst_n = 1'b1;
        set_mode(0);
        push(4'b0000, 37, 0, 0);
        pulse_start();
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
